fft_output_reorder: RTL and testbench
=====================================

FFT_OUTPUT_REORDER -- requirements
Module: fft_output_reorder

Interface
REQ-001 SHALL have parameter DATA_W, default 32, giving the width of each real or imaginary word (IEEE-754 single, treated as opaque bits).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_valid, input, 1, marking one group of four butterfly outputs valid this cycle.
REQ-005 SHALL have port in_ready, output, 1, high when a group is accepted this cycle.
REQ-006 SHALL have ports bf2_output_0_real..bf2_output_3_real, input, DATA_W each, lane 0..3 real parts.
REQ-007 SHALL have ports bf2_output_0_im..bf2_output_3_im, input, DATA_W each, lane 0..3 imaginary parts.
REQ-008 SHALL have port out_valid, output, 1, natural-order sample present.
REQ-009 SHALL have port out_ready, input, 1, downstream accepts the sample.
REQ-010 SHALL have ports out_real and out_im, output, DATA_W each, current bin value.
REQ-011 SHALL have port out_index, output, 4, bin number k of the current sample.
REQ-012 SHALL have port out_last, output, 1, high with bin 15.
REQ-013 SHALL have port ovf, output, 1, sticky overflow flag.

Function
REQ-014 SHALL hold two 16-entry complex banks (ping-pong), each with a full flag, plus write bank pointer, 2-bit write group counter, read bank pointer and 4-bit read index.
REQ-015 SHALL accept a group when in_valid && in_ready; group g (0..3, counted per frame) lane l SHALL be written to bin 4*l+g of the write bank (radix-4 digit reversal).
REQ-016 SHALL, on accepting group 3, set the write bank full flag, clear the group counter and toggle the write bank pointer.
REQ-017 SHALL drive in_ready = !full[write bank], from registered state only.
REQ-018 SHALL, when in_valid && !in_ready, discard the group, leave all counters unchanged and set ovf; ovf clears only on reset.
REQ-019 SHALL drive out_valid = full[read bank]; out_real, out_im SHALL be the read bank entry at read index, out_index = read index, out_last = out_valid && index==15.
REQ-020 SHALL drive out_real, out_im, out_index and out_last to 0 while out_valid is low.
REQ-021 SHALL advance the read index on out_valid && out_ready; with index 15 it SHALL clear that bank's full flag, wrap index to 0 and toggle the read bank pointer.
REQ-022 SHALL hold all out_* stable while out_valid && !out_ready.
REQ-023 Latency: out_valid SHALL rise the cycle after group 3 is accepted, bin 0 presented.
REQ-024 Simultaneous: a read release of one bank and a write completion into the other in the same cycle SHALL both take effect.
REQ-025 A bank released in cycle N SHALL show in_ready high from cycle N+1, never combinationally in cycle N.
REQ-026 Sustained throughput: one frame per 16 accepted reads; input may run at 4 groups per 16 cycles indefinitely without ovf.

Reset
REQ-027 On reset SHALL clear both full flags, all pointers, counters and ovf; next cycle in_valid/out_valid state: in_ready=1, out_valid=0, all out_* = 0.
REQ-028 Reset mid-frame or mid-read SHALL discard partial or unread frame contents; bank contents need not be cleared.

Verification
REQ-029 Single frame, out_ready=1: group g lane l real=im=float(4l+g) (e.g. g=0 lanes 0x00000000,0x40800000,0x41000000,0x41400000) -> 16 consecutive outputs with out_index 0..15, out_real=out_im=float(index), out_last only at 15, first out_valid cycle after 4th group.
REQ-030 Back-to-back frames: 3 frames offered continuously, out_ready=1 -> frames 1,2 accepted in 8 cycles, in_ready low until cycle after frame 1 bin 15, frame 3 then accepted; outputs contiguous 48 samples, ovf=0.
REQ-031 Backpressure: out_ready low for 5 cycles at index 7 -> out_index stays 7, data stable, resumes at 8 with no loss.
REQ-032 Overflow: both banks full, out_ready=0, in_valid pulsed with 0x3F800000 -> group ignored, ovf=1 and stays 1 after drain; contents unchanged.
REQ-033 Reset mid-read at index 5 -> next cycle out_valid=0, out_* = 0, in_ready=1, ovf=0; fresh frame then reorders correctly from bin 0.

Source files
------------

// File: rtl/fft_output_reorder_if.sv
// Bus bundle for fft_output_reorder: the four-lane butterfly input side with its
// valid/ready handshake, and the natural-order output stream with its handshake.
//   slave  : view taken by the reorder block (consumes groups, produces samples)
//   master : view taken by the surrounding logic (produces groups, consumes samples)
// Signals:
//   in_valid / in_ready               group handshake
//   bf2_output_{0..3}_real/_im        lane 0..3 complex words (opaque DATA_W bits)
//   out_valid / out_ready             sample handshake
//   out_real / out_im                 bin value, out_index bin number, out_last bin 15
//   ovf                               sticky flag, a group was offered while not ready
interface fft_output_reorder_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] bf2_output_0_real;
    logic [DATA_W-1:0] bf2_output_1_real;
    logic [DATA_W-1:0] bf2_output_2_real;
    logic [DATA_W-1:0] bf2_output_3_real;
    logic [DATA_W-1:0] bf2_output_0_im;
    logic [DATA_W-1:0] bf2_output_1_im;
    logic [DATA_W-1:0] bf2_output_2_im;
    logic [DATA_W-1:0] bf2_output_3_im;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_im;
    logic [3:0]        out_index;
    logic              out_last;
    logic              ovf;

    modport slave (
        input  in_valid,
        input  bf2_output_0_real, bf2_output_1_real, bf2_output_2_real, bf2_output_3_real,
        input  bf2_output_0_im, bf2_output_1_im, bf2_output_2_im, bf2_output_3_im,
        input  out_ready,
        output in_ready,
        output out_valid, out_real, out_im, out_index, out_last, ovf
    );

    modport master (
        output in_valid,
        output bf2_output_0_real, bf2_output_1_real, bf2_output_2_real, bf2_output_3_real,
        output bf2_output_0_im, bf2_output_1_im, bf2_output_2_im, bf2_output_3_im,
        output out_ready,
        input  in_ready,
        input  out_valid, out_real, out_im, out_index, out_last, ovf
    );
endinterface

// File: rtl/fft_output_reorder.sv
// Output reorder buffer for a 16-point radix-4 FFT.
// Groups of four butterfly outputs arrive in digit-reversed order; group g lane l
// belongs to bin 4*l+g. Two 16-entry complex banks are used ping-pong: one is filled
// while the other is streamed out in natural order (bins 0..15).
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset (clears flags, pointers, counters, ovf)
//   bus    fft_output_reorder_if.slave (input groups, output samples, ovf)
module fft_output_reorder #(
    parameter int unsigned DATA_W = 32
) (
    input logic                 clk,
    input logic                 reset,
    fft_output_reorder_if.slave bus
);

    // Bank storage is never reset; only the full flags decide what is valid.
    logic [DATA_W-1:0] bank_re_q [2][16];
    logic [DATA_W-1:0] bank_im_q [2][16];

    logic [1:0] full_q,    full_d;
    logic       wr_bank_q, wr_bank_d;
    logic [1:0] wr_grp_q,  wr_grp_d;
    logic       rd_bank_q, rd_bank_d;
    logic [3:0] rd_idx_q,  rd_idx_d;
    logic       ovf_q,     ovf_d;

    logic [DATA_W-1:0] lane_re [4];
    logic [DATA_W-1:0] lane_im [4];

    logic in_ready;
    logic out_valid;
    logic accept;
    logic rd_fire;

    always_comb begin
        lane_re[0] = bus.bf2_output_0_real;
        lane_re[1] = bus.bf2_output_1_real;
        lane_re[2] = bus.bf2_output_2_real;
        lane_re[3] = bus.bf2_output_3_real;
        lane_im[0] = bus.bf2_output_0_im;
        lane_im[1] = bus.bf2_output_1_im;
        lane_im[2] = bus.bf2_output_2_im;
        lane_im[3] = bus.bf2_output_3_im;
    end

    // Both handshakes derive from registered state only, so a bank released this
    // cycle becomes writable next cycle.
    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign accept    = bus.in_valid & in_ready;
    assign rd_fire   = out_valid & bus.out_ready;

    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        wr_grp_d  = wr_grp_q;
        rd_bank_d = rd_bank_q;
        rd_idx_d  = rd_idx_q;
        ovf_d     = ovf_q | (bus.in_valid & ~in_ready);

        // A completing write and a releasing read always target different banks
        // (one needs the flag clear, the other set), so both updates can apply.
        if (accept) begin
            wr_grp_d = wr_grp_q + 2'd1;
            if (wr_grp_q == 2'd3) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end

        if (rd_fire) begin
            rd_idx_d = rd_idx_q + 4'd1;
            if (rd_idx_q == 4'd15) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q    <= '0;
            wr_bank_q <= 1'b0;
            wr_grp_q  <= '0;
            rd_bank_q <= 1'b0;
            rd_idx_q  <= '0;
            ovf_q     <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            wr_grp_q  <= wr_grp_d;
            rd_bank_q <= rd_bank_d;
            rd_idx_q  <= rd_idx_d;
            ovf_q     <= ovf_d;
        end
    end

    // Radix-4 digit reversal: lane supplies the high digit, group the low digit.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int unsigned l = 0; l < 4; l++) begin
                bank_re_q[wr_bank_q][{2'(l), wr_grp_q}] <= lane_re[l];
                bank_im_q[wr_bank_q][{2'(l), wr_grp_q}] <= lane_im[l];
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_real  = out_valid ? bank_re_q[rd_bank_q][rd_idx_q] : '0;
    assign bus.out_im    = out_valid ? bank_im_q[rd_bank_q][rd_idx_q] : '0;
    assign bus.out_index = out_valid ? rd_idx_q : '0;
    assign bus.out_last  = out_valid & (rd_idx_q == 4'd15);
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_fft_output_reorder.sv
// Bench for fft_output_reorder. The reference model keeps a flat queue of
// natural-order samples still to be read; banks held = ceil(queue size / 16),
// the current bin index follows from how much of the head frame remains.
module tb_fft_output_reorder;

    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fft_output_reorder_if #(.DATA_W(DW)) bus ();

    fft_output_reorder #(.DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic [63:0] oq [$];     // pending output samples {re, im}, natural order
    logic [63:0] part [16];  // frame being assembled
    int          grp;
    bit          ovf_m;
    bit          last_acc;

    logic [DW-1:0] st_re [4];
    logic [DW-1:0] st_im [4];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] flt(input int n);
        logic [31:0] t [16];
        t = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
              32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
              32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
              32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
        return t[n];
    endfunction

    function automatic int cur_idx();
        return (16 - (oq.size() % 16)) % 16;
    endfunction

    task automatic model_clear();
        oq.delete();
        grp   = 0;
        ovf_m = 0;
    endtask

    // One clock: drive at the negedge, check all outputs, then advance the model.
    task automatic cycle(input bit iv, input bit ordy);
        int          held;
        logic [63:0] head;
        bit          acc, fire;
        bus.in_valid          = iv;
        bus.out_ready         = ordy;
        bus.bf2_output_0_real = st_re[0];
        bus.bf2_output_1_real = st_re[1];
        bus.bf2_output_2_real = st_re[2];
        bus.bf2_output_3_real = st_re[3];
        bus.bf2_output_0_im   = st_im[0];
        bus.bf2_output_1_im   = st_im[1];
        bus.bf2_output_2_im   = st_im[2];
        bus.bf2_output_3_im   = st_im[3];
        #1;
        held = (oq.size() + 15) / 16;
        head = (oq.size() > 0) ? oq[0] : 64'd0;
        chk("in_ready",  64'(bus.in_ready),  64'(held < 2));
        chk("out_valid", 64'(bus.out_valid), 64'(oq.size() > 0));
        chk("out_real",  64'(bus.out_real),  64'(head[63:32]));
        chk("out_im",    64'(bus.out_im),    64'(head[31:0]));
        chk("out_index", 64'(bus.out_index), 64'(cur_idx()));
        chk("out_last",  64'(bus.out_last),  64'(oq.size() % 16 == 1));
        chk("ovf",       64'(bus.ovf),       64'(ovf_m));
        acc  = iv && (held < 2);
        fire = (oq.size() > 0) && ordy;
        @(posedge clk);
        if (fire) void'(oq.pop_front());
        if (acc) begin
            for (int l = 0; l < 4; l++) part[4*l + grp] = {st_re[l], st_im[l]};
            grp++;
            if (grp == 4) begin
                for (int k = 0; k < 16; k++) oq.push_back(part[k]);
                grp = 0;
            end
        end
        if (iv && !(held < 2)) ovf_m = 1;
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_float_group(input int g);
        for (int l = 0; l < 4; l++) begin
            st_re[l] = flt(4*l + g);
            st_im[l] = flt(4*l + g);
        end
    endtask

    // Offer n groups (float pattern), holding each until accepted; returns cycles used.
    task automatic offer(input int n, input bit ordy, output int cyc);
        int g = 0;
        cyc = 0;
        while (g < n && cyc < 200) begin
            set_float_group(g % 4);
            cycle(1'b1, ordy);
            if (last_acc) g++;
            cyc++;
        end
        chk("offer_done", 64'(g), 64'(n));
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, ordy);
    endtask

    task automatic run_to_idx(input int target);
        int c = 0;
        while (!(oq.size() > 0 && cur_idx() == target) && c < 40) begin
            cycle(1'b0, 1'b1);
            c++;
        end
        chk("reach_idx", 64'(cur_idx()), 64'(target));
    endtask

    initial begin
        int cyc;
        for (int l = 0; l < 4; l++) begin
            st_re[l] = '0;
            st_im[l] = '0;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        model_clear();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state, then single frame with out_ready high.
        idle(2, 1'b1);
        offer(4, 1'b1, cyc);
        chk("single_first_valid", 64'(bus.out_valid), 64'd1);
        idle(20, 1'b1);

        // Three frames back to back: first two in 8 cycles.
        do_reset();
        offer(8, 1'b1, cyc);
        chk("b2b_two_frames_cycles", 64'(cyc), 64'd8);
        offer(4, 1'b1, cyc);
        idle(50, 1'b1);

        // Backpressure at index 7.
        do_reset();
        offer(4, 1'b0, cyc);
        run_to_idx(7);
        idle(5, 1'b0);
        chk("bp_hold_idx", 64'(bus.out_index), 64'd7);
        idle(20, 1'b1);

        // Overflow with both banks full.
        do_reset();
        offer(8, 1'b0, cyc);
        for (int l = 0; l < 4; l++) begin
            st_re[l] = 32'h3F800000;
            st_im[l] = 32'h3F800000;
        end
        cycle(1'b1, 1'b0);
        chk("ovf_set", 64'(bus.ovf), 64'd1);
        idle(40, 1'b1);
        chk("ovf_sticky", 64'(bus.ovf), 64'd1);

        // Reset in the middle of a read.
        do_reset();
        offer(4, 1'b1, cyc);
        run_to_idx(5);
        do_reset();
        chk("rst_mid_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_mid_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_mid_ovf", 64'(bus.ovf), 64'd0);
        idle(1, 1'b1);
        offer(4, 1'b1, cyc);
        idle(20, 1'b1);

        // Randomised traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int l = 0; l < 4; l++) begin
                st_re[l] = $urandom;
                st_im[l] = $urandom;
            end
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0);
        end
        idle(40, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
